calc_cmd_loader: RTL

Byte-stream command front end for the 16-bit integer calculator. It receives a 5-byte command frame over a valid/ready byte interface and drives the calculator's operation and operand inputs. It waits a fixed settle latency, captures the 16-bit result and returns it on a valid/ready result interface with an error flag. It sits directly upstream of the calculator datapath and also consumes the calculator's result.

---
 rtl/calc_pkg.sv | 27 ++
 rtl/calc_cmd_loader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command front end: opcodes, frame
// length and loader state encoding.
package calc_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_MOD = 3'd4;

   localparam int FRAME_LEN = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OPA_H = 3'd1,
      ST_OPA_L = 3'd2,
      ST_OPB_H = 3'd3,
      ST_OPB_L = 3'd4,
      ST_WAIT  = 3'd5,
      ST_RESP  = 3'd6
   } ld_state_e;

   function automatic logic op_is_valid(input logic [2:0] op);
      return (op <= OP_MOD);
   endfunction

endpackage

// File: rtl/calc_cmd_loader.sv
// Byte-stream command loader: collects a 5-byte frame, drives the calculator,
// waits CALC_LAT cycles and returns the result. Optional CALC_DIV0_CHECK_EN
// adds a division/modulo-by-zero check that short-cuts to an error response.
//
// state    | meaning
// ST_IDLE  | waiting for opcode byte
// ST_OPA_H | waiting for opa[15:8]
// ST_OPA_L | waiting for opa[7:0]
// ST_OPB_H | waiting for opb[15:8]
// ST_OPB_L | waiting for opb[7:0]
// ST_WAIT  | calculator settling, counter running
// ST_RESP  | result held until res_ready
module calc_cmd_loader
   import calc_pkg::*;
#(
   parameter int unsigned CALC_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic [2:0]  calc_op,
   output logic [15:0] calc_opa,
   output logic [15:0] calc_opb,
   input  logic [15:0] calc_res,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic        res_err
);

   localparam logic [3:0] LAT_LD = 4'(CALC_LAT);

   ld_state_e   state_q;
   logic [3:0]  cnt_q;
   logic        op_err_q;
   logic [2:0]  calc_op_q;
   logic [15:0] calc_opa_q;
   logic [15:0] calc_opb_q;
   logic        res_valid_q;
   logic [15:0] res_data_q;
   logic        res_err_q;
   logic        in_fire;
   logic        fast_err;

   // in_ready is gated by rst so it reads low during reset even though the
   // state register already sits in IDLE.
   assign in_ready = !rst && (state_q inside {ST_IDLE, ST_OPA_H, ST_OPA_L, ST_OPB_H, ST_OPB_L});
   assign in_fire  = in_valid && in_ready;

`ifdef CALC_DIV0_CHECK_EN
   logic div0;
   assign div0     = ((calc_op_q == OP_DIV) || (calc_op_q == OP_MOD)) &&
                     ({calc_opb_q[15:8], in_data} == 16'd0);
   assign fast_err = op_err_q || div0;
`else
   assign fast_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         op_err_q    <= 1'b0;
         calc_op_q   <= OP_ADD;
         calc_opa_q  <= '0;
         calc_opb_q  <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (in_fire) begin
               op_err_q  <= !op_is_valid(in_data[2:0]);
               calc_op_q <= op_is_valid(in_data[2:0]) ? in_data[2:0] : OP_ADD;
               state_q   <= ST_OPA_H;
            end
            ST_OPA_H: if (in_fire) begin
               calc_opa_q[15:8] <= in_data;
               state_q          <= ST_OPA_L;
            end
            ST_OPA_L: if (in_fire) begin
               calc_opa_q[7:0] <= in_data;
               state_q         <= ST_OPB_H;
            end
            ST_OPB_H: if (in_fire) begin
               calc_opb_q[15:8] <= in_data;
               state_q          <= ST_OPB_L;
            end
            ST_OPB_L: if (in_fire) begin
               calc_opb_q[7:0] <= in_data;
               if (fast_err) begin
                  state_q <= ST_RESP;
               end else begin
                  cnt_q   <= LAT_LD;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_q <= 4'd1) begin
                  cnt_q       <= '0;
                  res_valid_q <= 1'b1;
                  res_data_q  <= op_err_q ? 16'd0 : calc_res;
                  res_err_q   <= op_err_q;
                  state_q     <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            ST_RESP: begin
               // Entered without a valid result only via the error fast-path.
               if (!res_valid_q) begin
                  res_valid_q <= 1'b1;
                  res_data_q  <= '0;
                  res_err_q   <= 1'b1;
               end else if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign calc_op   = calc_op_q;
   assign calc_opa  = calc_opa_q;
   assign calc_opb  = calc_opb_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_err   = res_err_q;

endmodule
